// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF measurement controller: enables two challenge-selected oscillators,
// counts their synchronised rising edges over a programmable window and compares the counts.
module ro_puf_ctrl #(
  parameter int NUM_RO     = 8,
  parameter int SEL_W      = $clog2(NUM_RO),
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [WIN_W-1:0]  window,
  output logic              busy,
  output logic              done,
  output logic              resp,
  output logic              tie,
  output logic              err,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [NUM_RO-1:0] r_sync1;
  logic [NUM_RO-1:0] r_sync2;
  logic [NUM_RO-1:0] r_sync3;
  logic [NUM_RO-1:0] r_pulse;

  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic [WIN_W-1:0]  r_window;
  logic [TMR_W-1:0]  r_timer;
  logic [NUM_RO-1:0] r_ro_en;
  logic              r_busy;
  logic              r_done;
  logic              r_resp;
  logic              r_tie;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt_a;
  logic [CNT_W-1:0]  r_cnt_b;

  logic [NUM_RO-1:0] w_req_mask;
  logic [NUM_RO-1:0] w_hit_a;
  logic [NUM_RO-1:0] w_hit_b;
  logic              w_illegal;
  logic              w_pulse_a;
  logic              w_pulse_b;
  logic              w_timer_zero;
  logic [CNT_W-1:0]  w_cnt_a_next;
  logic [CNT_W-1:0]  w_cnt_b_next;

  // One-hot decode of the incoming challenge (for ro_en) and of the latched one (for counting)
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RO; gi++) begin : g_sel
      assign w_req_mask[gi] = (sel_a == SEL_W'(gi)) || (sel_b == SEL_W'(gi));
      assign w_hit_a[gi]    = (r_sel_a == SEL_W'(gi));
      assign w_hit_b[gi]    = (r_sel_b == SEL_W'(gi));
    end
  endgenerate

  assign w_illegal    = (sel_a == sel_b) || (int'(sel_a) >= NUM_RO) ||
                        (int'(sel_b) >= NUM_RO) || (window == '0);
  assign w_pulse_a    = |(r_pulse & w_hit_a);
  assign w_pulse_b    = |(r_pulse & w_hit_b);
  assign w_timer_zero = (r_timer == '0);

  // Saturating increments: a full counter stays full rather than wrapping
  assign w_cnt_a_next = (w_pulse_a && (r_cnt_a != {CNT_W{1'b1}})) ? r_cnt_a + CNT_W'(1) : r_cnt_a;
  assign w_cnt_b_next = (w_pulse_b && (r_cnt_b != {CNT_W{1'b1}})) ? r_cnt_b + CNT_W'(1) : r_cnt_b;

  // Two-flop synchroniser, history flop and registered rising-edge pulse per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= ro_out;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_illegal ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_timer_zero) begin
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_timer_zero) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a  <= '0;
      r_sel_b  <= '0;
      r_window <= '0;
      r_timer  <= '0;
      r_ro_en  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resp   <= 1'b0;
      r_tie    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel_a  <= sel_a;
            r_sel_b  <= sel_b;
            r_window <= window;
            r_timer  <= TMR_W'(SETTLE_CYC - 1);
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_resp   <= 1'b0;
            r_tie    <= 1'b0;
            r_err    <= w_illegal;
            if (w_illegal) begin
              r_done <= 1'b1;
            end else begin
              r_ro_en <= w_req_mask;
            end
          end
        end
        S_SETTLE: begin
          if (w_timer_zero) begin
            r_timer <= TMR_W'(r_window) - TMR_W'(1);
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_COUNT: begin
          r_cnt_a <= w_cnt_a_next;
          r_cnt_b <= w_cnt_b_next;
          if (w_timer_zero) begin
            // Compare the final counts, including this cycle's pulses
            r_resp  <= (w_cnt_a_next > w_cnt_b_next);
            r_tie   <= (w_cnt_a_next == w_cnt_b_next);
            r_done  <= 1'b1;
            r_ro_en <= '0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ro_en = r_ro_en;
  assign busy  = r_busy;
  assign done  = r_done;
  assign resp  = r_resp;
  assign tie   = r_tie;
  assign err   = r_err;
  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl: free-running model oscillators with fixed periods,
// a main instance (4-bit selects) and a 4-bit-counter instance for saturation.
module tb_ro_puf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ro_out = '0;

  logic        m_start = 1'b0;
  logic [3:0]  m_sel_a = '0;
  logic [3:0]  m_sel_b = '0;
  logic [15:0] m_win = '0;
  logic [7:0]  m_ro_en;
  logic        m_busy, m_done, m_resp, m_tie, m_err;
  logic [15:0] m_cnt_a, m_cnt_b;

  logic        s_start = 1'b0;
  logic [2:0]  s_sel_a = '0;
  logic [2:0]  s_sel_b = '0;
  logic [15:0] s_win = '0;
  logic [7:0]  s_ro_en;
  logic        s_busy, s_done, s_resp, s_tie, s_err;
  logic [3:0]  s_cnt_a, s_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Half periods in clk cycles; channels 2 and 3 are identical and in phase
  localparam int HALF [8] = '{4, 6, 5, 5, 2, 3, 7, 7};
  int tns = 0;
  always #1 begin
    tns = tns + 1;
    for (int i = 0; i < 8; i++) ro_out[i] = ((tns / (HALF[i] * 10)) % 2) != 0;
  end

  ro_puf_ctrl #(.NUM_RO(8), .SEL_W(4), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(4)) u_main (
    .clk(clk), .rst_n(rst_n), .ro_out(ro_out), .ro_en(m_ro_en), .start(m_start),
    .sel_a(m_sel_a), .sel_b(m_sel_b), .window(m_win), .busy(m_busy), .done(m_done),
    .resp(m_resp), .tie(m_tie), .err(m_err), .cnt_a(m_cnt_a), .cnt_b(m_cnt_b)
  );

  ro_puf_ctrl #(.NUM_RO(8), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .ro_out(ro_out), .ro_en(s_ro_en), .start(s_start),
    .sel_a(s_sel_a), .sel_b(s_sel_b), .window(s_win), .busy(s_busy), .done(s_done),
    .resp(s_resp), .tie(s_tie), .err(s_err), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  // Issue one start on the main instance; dn is the cycle (1 = cycle after the start edge) of done
  task automatic run_main(input logic [3:0] sa, input logic [3:0] sb, input logic [15:0] w,
                          input int budget, output int dn, output logic en_nz);
    dn = -1;
    en_nz = 1'b0;
    @(negedge clk);
    m_sel_a = sa; m_sel_b = sb; m_win = w; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (n > 1) @(negedge clk);
      if (m_ro_en != 8'h00) en_nz = 1'b1;
      if (m_done) begin
        dn = n;
        break;
      end
    end
    $display("run sel_a=%0d sel_b=%0d window=%0d done@%0d cnt_a=%0d cnt_b=%0d resp=%0b tie=%0b err=%0b",
             sa, sb, w, dn, m_cnt_a, m_cnt_b, m_resp, m_tie, m_err);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({m_ro_en, m_busy, m_done, m_resp, m_tie, m_err, m_cnt_a, m_cnt_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ro_en=%h busy=%b done=%b cnt_a=%0d cnt_b=%0d, need all 0",
               m_ro_en, m_busy, m_done, m_cnt_a, m_cnt_b);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_busy !== 1'b0 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got main=%b sat=%b, need 0", m_busy, s_busy);
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    int dn;
    logic en_nz;
    run_main(4'd0, 4'd1, 16'd96, 150, dn, en_nz);
    n_cmp++;
    if (dn !== 101) begin n_bad++; $display("FAIL basic_done_cycle: got %0d need 101", dn); end
    n_cmp++;
    if (m_cnt_a < 16'd11 || m_cnt_a > 16'd13) begin
      n_bad++; $display("FAIL basic_cnt_a: got %0d need 12+-1", m_cnt_a);
    end
    n_cmp++;
    if (m_cnt_b < 16'd7 || m_cnt_b > 16'd9) begin
      n_bad++; $display("FAIL basic_cnt_b: got %0d need 8+-1", m_cnt_b);
    end
    n_cmp++;
    if ({m_resp, m_tie, m_err} !== 3'b100) begin
      n_bad++; $display("FAIL basic_flags: got resp/tie/err=%b need 100", {m_resp, m_tie, m_err});
    end
    @(negedge clk);
    n_cmp++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      n_bad++; $display("FAIL basic_after_done: got busy=%b done=%b need 0 0", m_busy, m_done);
    end
    n_cmp++;
    if (m_resp !== 1'b1 || m_cnt_a < 16'd11 || m_cnt_a > 16'd13) begin
      n_bad++; $display("FAIL basic_hold: got resp=%b cnt_a=%0d need 1 and 12+-1", m_resp, m_cnt_a);
    end
  endtask

  task automatic test_swap_tie();
    int dn;
    logic en_nz;
    run_main(4'd1, 4'd0, 16'd96, 150, dn, en_nz);
    n_cmp++;
    if ({m_resp, m_tie} !== 2'b00 || m_cnt_a < 16'd7 || m_cnt_a > 16'd9) begin
      n_bad++; $display("FAIL swap_result: got resp/tie=%b cnt_a=%0d need 00 and 8+-1", {m_resp, m_tie}, m_cnt_a);
    end
    run_main(4'd2, 4'd3, 16'd100, 150, dn, en_nz);
    n_cmp++;
    if (dn !== 105) begin n_bad++; $display("FAIL tie_done_cycle: got %0d need 105", dn); end
    n_cmp++;
    if ({m_resp, m_tie} !== 2'b01) begin
      n_bad++; $display("FAIL tie_flags: got resp/tie=%b need 01", {m_resp, m_tie});
    end
    n_cmp++;
    if (m_cnt_a < 16'd9 || m_cnt_a > 16'd11) begin
      n_bad++; $display("FAIL tie_cnt_a: got %0d need 10+-1", m_cnt_a);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  sa_t [3] = '{4'd3, 4'd0, 4'd8};
    logic [3:0]  sb_t [3] = '{4'd3, 4'd1, 4'd1};
    logic [15:0] w_t  [3] = '{16'd10, 16'd0, 16'd10};
    int dn;
    logic en_nz;
    for (int i = 0; i < 3; i++) begin
      run_main(sa_t[i], sb_t[i], w_t[i], 20, dn, en_nz);
      n_cmp++;
      if (dn !== 1) begin n_bad++; $display("FAIL illegal%0d_done_cycle: got %0d need 1", i, dn); end
      n_cmp++;
      if ({m_err, m_resp, m_tie} !== 3'b100 || m_cnt_a !== 16'd0 || m_cnt_b !== 16'd0) begin
        n_bad++;
        $display("FAIL illegal%0d_result: got err/resp/tie=%b cnt_a=%0d cnt_b=%0d need 100 0 0",
                 i, {m_err, m_resp, m_tie}, m_cnt_a, m_cnt_b);
      end
      n_cmp++;
      if (en_nz !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_ro_en: got nonzero need 0", i); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int dn = -1;
    @(negedge clk);
    s_sel_a = 3'd4; s_sel_b = 3'd0; s_win = 16'd200; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      if (n > 1) @(negedge clk);
      if (s_done) begin dn = n; break; end
    end
    $display("sat run sel_a=4 sel_b=0 window=200 done@%0d cnt_a=%0d cnt_b=%0d", dn, s_cnt_a, s_cnt_b);
    n_cmp++;
    if (dn !== 205) begin n_bad++; $display("FAIL sat_done_cycle: got %0d need 205", dn); end
    n_cmp++;
    if (s_cnt_a !== 4'd15) begin n_bad++; $display("FAIL sat_cnt_a: got %0d need 15", s_cnt_a); end
    n_cmp++;
    if (s_err !== 1'b0 || s_cnt_b !== 4'd15) begin
      n_bad++; $display("FAIL sat_cnt_b: got cnt_b=%0d err=%b need 15 0", s_cnt_b, s_err);
    end
  endtask

  task automatic test_busy_enable();
    int en_bad = 0;
    int n_done = 0;
    int done_at = -1;
    logic [7:0] exp_en;
    @(negedge clk);
    m_sel_a = 4'd0; m_sel_b = 4'd5; m_win = 16'd40; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      exp_en = (n <= 44) ? 8'h21 : 8'h00;
      if (m_ro_en !== exp_en) en_bad++;
      if (m_done) begin n_done++; done_at = n; end
      if (n == 20) begin
        m_sel_a = 4'd6; m_sel_b = 4'd7; m_win = 16'd5; m_start = 1'b1;
      end else begin
        m_start = 1'b0;
      end
    end
    $display("busy run sel_a=0 sel_b=5 window=40 dones=%0d done@%0d cnt_a=%0d cnt_b=%0d", n_done, done_at, m_cnt_a, m_cnt_b);
    n_cmp++;
    if (en_bad !== 0) begin n_bad++; $display("FAIL busy_ro_en: got %0d wrong cycles need 0", en_bad); end
    n_cmp++;
    if (n_done !== 1 || done_at !== 45) begin
      n_bad++; $display("FAIL busy_single_done: got %0d dones at %0d need 1 at 45", n_done, done_at);
    end
    n_cmp++;
    if (m_cnt_a < 16'd4 || m_cnt_a > 16'd6 || m_cnt_b < 16'd6 || m_cnt_b > 16'd7 || m_resp !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_result: got cnt_a=%0d cnt_b=%0d resp=%b need 4..6 6..7 0", m_cnt_a, m_cnt_b, m_resp);
    end
  endtask

  task automatic test_reset_midrun();
    int dn;
    logic en_nz;
    int n_done = 0;
    @(negedge clk);
    m_sel_a = 4'd0; m_sel_b = 4'd1; m_win = 16'd96; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_ro_en, m_busy, m_done, m_resp, m_tie, m_err, m_cnt_a, m_cnt_b} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset_outputs: got ro_en=%h busy=%b cnt_a=%0d cnt_b=%0d need all 0",
               m_ro_en, m_busy, m_cnt_a, m_cnt_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (m_done) n_done++;
    end
    $display("midrun reset released, dones after=%0d", n_done);
    n_cmp++;
    if (n_done !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d need 0", n_done); end
    run_main(4'd0, 4'd1, 16'd96, 150, dn, en_nz);
    n_cmp++;
    if (dn !== 101 || m_resp !== 1'b1 || m_cnt_a < 16'd11 || m_cnt_a > 16'd13) begin
      n_bad++;
      $display("FAIL midrun_fresh_run: got done@%0d resp=%b cnt_a=%0d need 101 1 12+-1", dn, m_resp, m_cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap_tie();
    test_illegal();
    test_saturation();
    test_busy_enable();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Measurement controller for the ring-oscillator PUF, and the parametrised successor to the fixed four-oscillator cells. It enables two of `NUM_RO` oscillator cells selected by a challenge and counts their rising edges over a programmable window in the `clk` domain. It then compares the counts to produce one response bit. The block sits between the oscillator array and the challenge/response host logic.

## Interface
- `NUM_RO`, 8: number of oscillator channels (≥2).
- `SEL_W`, `$clog2(NUM_RO)`: challenge select width.
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: window-length width.
- `SETTLE_CYC`, 4: cycles the oscillators run before counting starts (≥3, covers synchroniser fill).

Ports:
- `clk` input 1: single system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `ro_out` input `NUM_RO`: raw oscillator outputs, asynchronous to `clk`.
- `ro_en` output `NUM_RO`: per-oscillator enable.
- `start` input 1: request a measurement.
- `sel_a` input `SEL_W`: first challenge channel.
- `sel_b` input `SEL_W`: second challenge channel.
- `window` input `WIN_W`: counting window length in `clk` cycles.
- `busy` output 1: measurement in progress.
- `done` output 1: one-cycle pulse; results valid.
- `resp` output 1: response bit, `cnt_a > cnt_b`.
- `tie` output 1: `cnt_a == cnt_b`.
- `err` output 1: illegal challenge.
- `cnt_a` output `CNT_W`: edge count of channel `sel_a`.
- `cnt_b` output `CNT_W`: edge count of channel `sel_b`.

## Operation
- Every `ro_out` bit passes through a 2-flop synchroniser, then a rising-edge detector (sync2 high, previous low).
- FSM states are IDLE, SETTLE, COUNT and DONE.
- IDLE:
  - `busy`=0 and `ro_en`=0.
  - When `start`=1, the block latches `sel_a`, `sel_b` and `window`.
  - It then clears `cnt_a`, `cnt_b`, `resp`, `tie` and `err`.
  - If the challenge is legal, the FSM moves to SETTLE.
  - If the challenge is illegal, the FSM moves to DONE with `err`=1.
- A challenge is illegal if `sel_a==sel_b`, `sel_a>=NUM_RO`, `sel_b>=NUM_RO`, or `window==0`.
- SETTLE:
  - `ro_en` has exactly bits `sel_a` and `sel_b` set.
  - Lasts `SETTLE_CYC` cycles; edges are not counted.
- COUNT:
  - `ro_en` is unchanged from SETTLE.
  - Lasts `window` cycles.
  - Each cycle with an edge pulse on channel `sel_a` increments `cnt_a`; likewise for `sel_b` and `cnt_b`.
  - Counters saturate at 2^`CNT_W`−1 and never wrap.
- DONE:
  - Lasts one cycle; `ro_en`=0, `done`=1.
  - `resp` = (`cnt_a` > `cnt_b`) and `tie` = (`cnt_a` == `cnt_b`), both registered on entry to DONE.
  - If `err`=1, then `resp`=0, `tie`=0 and both counts are 0.
  - The FSM returns to IDLE.
- `busy` is 1 in SETTLE, COUNT and DONE.
- `start` while `busy`=1 is ignored. There is no queueing.
- Changes on `sel_*` or `window` after acceptance have no effect.
- `resp`, `tie`, `err`, `cnt_a` and `cnt_b` hold their values until the next accepted `start`.
- Reset (asynchronous, any state):
  - Sets FSM=IDLE.
  - Drives every output to 0, including `ro_en`.
  - Clears the synchronisers.
  - An in-flight measurement is discarded and produces no `done`.

## Timing
- `start` sampled high in IDLE at edge k gives `busy`=1 from k+1.
- SETTLE occupies cycles k+1 … k+`SETTLE_CYC`.
- COUNT occupies the next `window` cycles.
- Legal challenge: `done`=1 in cycle k+1+`SETTLE_CYC`+`window`. Results are valid in that cycle and stay stable afterwards.
- Illegal challenge: `done`=1 in cycle k+1.
- `busy` falls one cycle after `done`. A new `start` is accepted at the first edge where the FSM is back in IDLE.
- Oscillator-to-count latency is 3 `clk` cycles (sync2 plus edge register). Edges arriving within the last 3 COUNT cycles are not counted.
- Every output is registered; `ro_en` is glitch-free.

## Test plan
- **Basic compare:** bench models `ro_out[0]` with an 8-cycle period and `ro_out[1]` with a 12-cycle period. Inputs are `sel_a`=0, `sel_b`=1, `window`=96. Required: `done` at k+101, `cnt_a`=12±1, `cnt_b`=8±1, `resp`=1, `tie`=0.
- **Swap and tie:** the same oscillators with `sel_a`=1, `sel_b`=0 give `resp`=0. Two identical 10-cycle oscillators give `tie`=1, `resp`=0.
- **Illegal challenge:** `sel_a`=`sel_b`=3 gives `done` at k+1 with `err`=1, `ro_en` never nonzero, and counts 0. `window`=0 and `sel_a`=8 (with `NUM_RO`=8) each give the same result.
- **Saturation:** with `CNT_W`=4, a 4-cycle oscillator and `window`=200, `cnt_a`=15 with no wrap.
- **Busy and enable:** `start` pulses during COUNT are ignored and the single `done` is unchanged. `ro_en` equals `8'b0010_0001` for `sel_a`=0, `sel_b`=5 throughout SETTLE and COUNT, and 0 otherwise.
- **Reset mid-run:** asserting `rst_n`=0 during COUNT drives all outputs to 0 immediately and produces no `done`. After release, a fresh measurement completes correctly.
